// File: rtl/brightness_auto_coe.sv
// brightness_auto_coe: per-frame luma mean and brightness coefficient.
// Sums Y over the active pixels of a frame. On each vertical-sync rising edge
// it divides the sum by the pixel count with a restoring divider. It then
// publishes mean_o and a clamped, signed (target - mean) coefficient for the
// brightness filter.
module brightness_auto_coe #(
  parameter int PIXEL_WIDTH = 8,
  parameter int COE_WIDTH   = 9,
  parameter int CNT_WIDTH   = 22
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic [PIXEL_WIDTH-1:0] target_i,
  input  logic [PIXEL_WIDTH-1:0] y_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [15:0]            coe_o,
  output logic                   coe_vld_o,
  output logic [PIXEL_WIDTH-1:0] mean_o,
  output logic                   busy_o
);

  localparam int DIV_W = PIXEL_WIDTH + CNT_WIDTH;
  localparam int BIT_W = $clog2(DIV_W + 1);
  localparam logic signed [15:0] C_MAX = 16'((2 ** (COE_WIDTH - 1)) - 1);
  localparam logic signed [15:0] C_MIN = 16'(-(2 ** (COE_WIDTH - 1)));

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIV    = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_vs_q;
  logic [DIV_W-1:0]       r_sum;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   r_rem;
  logic [DIV_W-1:0]       r_quo;
  logic [CNT_WIDTH-1:0]   r_den;
  logic [BIT_W-1:0]       r_bit;

  logic                   w_edge;
  logic                   w_pix;
  logic                   w_accept;
  logic [CNT_WIDTH:0]     w_shift;
  logic [CNT_WIDTH:0]     w_sub;
  logic                   w_ge;
  logic signed [PIXEL_WIDTH:0] w_diff;
  logic signed [15:0]     w_diff16;
  logic signed [15:0]     w_clamp;
  logic [1:0]             w_unused;

  // hs_i has no role here; the top subtract bit is always zero when kept
  assign w_unused = {hs_i, w_sub[CNT_WIDTH]};

  // A new frame starts on the rising edge of vertical sync
  assign w_edge   = vs_i & ~r_vs_q;
  // Counting stops once the pixel counter saturates so sum/cnt stay coherent
  assign w_pix    = de_i & ~vs_i & ~(&r_cnt);
  assign w_accept = w_edge & (r_state == S_IDLE) & (|r_cnt);

  // Restoring-division step: remainder is always below the divisor (< 2^CNT_WIDTH)
  assign w_shift  = {r_rem, r_quo[DIV_W-1]};
  assign w_ge     = (w_shift >= {1'b0, r_den});
  assign w_sub    = w_shift - {1'b0, r_den};

  // Signed difference between desired and measured mean
  assign w_diff   = $signed({1'b0, target_i}) - $signed({1'b0, r_quo[PIXEL_WIDTH-1:0]});
  assign w_diff16 = 16'(w_diff);

  assign busy_o   = (r_state == S_DIV);

  // Clamp the difference into the filter's coefficient range
  always_comb begin
    w_clamp = w_diff16;
    if (w_diff16 > C_MAX) begin
      w_clamp = C_MAX;
    end else if (w_diff16 < C_MIN) begin
      w_clamp = C_MIN;
    end else begin
      w_clamp = w_diff16;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state: divide for exactly DIV_W cycles, then one update cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = S_DIV;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_DIV: begin
        if (r_bit == BIT_W'(DIV_W - 1)) begin
          w_next = S_UPDATE;
        end else begin
          w_next = S_DIV;
        end
      end
      S_UPDATE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Frame accumulation, divider datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_q    <= 1'b0;
      r_sum     <= '0;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_den     <= '0;
      r_bit     <= '0;
      coe_o     <= 16'd0;
      coe_vld_o <= 1'b0;
      mean_o    <= '0;
    end else begin
      r_vs_q    <= vs_i;
      coe_vld_o <= 1'b0;
      // The edge cycle clears the accumulators; accumulation goes on during division
      if (w_edge) begin
        r_sum <= '0;
        r_cnt <= '0;
      end else if (w_pix) begin
        r_sum <= r_sum + DIV_W'(y_i);
        r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rem <= '0;
            r_quo <= r_sum;
            r_den <= r_cnt;
            r_bit <= '0;
          end
          if (!en_i) begin
            coe_o <= 16'd0;
          end
        end
        S_DIV: begin
          r_rem <= w_ge ? w_sub[CNT_WIDTH-1:0] : w_shift[CNT_WIDTH-1:0];
          r_quo <= {r_quo[DIV_W-2:0], w_ge};
          r_bit <= r_bit + {{(BIT_W-1){1'b0}}, 1'b1};
        end
        S_UPDATE: begin
          mean_o    <= r_quo[PIXEL_WIDTH-1:0];
          coe_o     <= en_i ? w_clamp : 16'd0;
          coe_vld_o <= 1'b1;
        end
        default: begin
          r_bit <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brightness_auto_coe.sv
// Testbench for brightness_auto_coe: table-driven frames, corner sequences and
// random frames checked against a frame-level arithmetic model.
module tb_brightness_auto_coe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_i = 1'b1;
  logic [7:0]  target_i = 8'd0;
  logic [7:0]  y_i = 8'd0;
  logic        de_i = 1'b0;
  logic        hs_i = 1'b0;
  logic        vs_i = 1'b0;
  logic [15:0] coe_o, coe7;
  logic        coe_vld_o, vld7;
  logic [7:0]  mean_o, mean7;
  logic        busy_o, busy7;

  int n_tests = 0;
  int n_fail  = 0;
  int q_pix[$];
  int prev_mean = 0;
  logic [15:0] prev_coe = 16'd0;
  logic [15:0] prev_coe7 = 16'd0;

  typedef struct {
    int n; int ya; int yb; int tgt; int en;
    int mean; logic [15:0] coe; logic [15:0] coe7;
  } vec_t;
  vec_t tbl[8];

  brightness_auto_coe dut (
    .clk(clk), .rst(rst), .en_i(en_i), .target_i(target_i), .y_i(y_i),
    .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .coe_o(coe_o),
    .coe_vld_o(coe_vld_o), .mean_o(mean_o), .busy_o(busy_o)
  );

  brightness_auto_coe #(.COE_WIDTH(7)) dut7 (
    .clk(clk), .rst(rst), .en_i(en_i), .target_i(target_i), .y_i(y_i),
    .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .coe_o(coe7),
    .coe_vld_o(vld7), .mean_o(mean7), .busy_o(busy7)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: coefficient from the frame mean, clamped to a cw-bit signed range
  function automatic logic [15:0] model_coe(int mean, int tgt, int en, int cw);
    int d, hi, lo;
    if (en == 0) return 16'd0;
    d  = tgt - mean;
    hi = (1 << (cw - 1)) - 1;
    lo = -(1 << (cw - 1));
    if (d > hi) d = hi;
    else if (d < lo) d = lo;
    return 16'(d);
  endfunction

  // Drive q_pix as one frame, raise vs, and watch for the coefficient pulse
  task automatic run_frame(input string nm, input int tgt, input int en, input int exp_pulses,
                           input int exp_mean, input logic [15:0] exp_coe,
                           input logic [15:0] exp_coe7, input int vs2_at, input int rst_at);
    int lat, busy_n, pulses, pulses7;
    target_i = 8'(tgt);
    en_i     = (en != 0);
    foreach (q_pix[i]) begin
      @(posedge clk); #1;
      de_i = 1'b1; y_i = 8'(q_pix[i]); vs_i = 1'b0; hs_i = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    de_i = 1'b0; vs_i = 1'b1; y_i = 8'($urandom_range(0, 255));
    lat = 0; busy_n = 0; pulses = 0; pulses7 = 0;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      if (busy_o) busy_n++;
      if (vld7) pulses7++;
      if (coe_vld_o) begin
        pulses++;
        if (lat == 0) lat = k;
      end
      vs_i = (k < 3) || (vs2_at != 0 && k >= vs2_at && k < vs2_at + 3);
      de_i = (vs2_at != 0 && k >= 4 && k < 9);
      y_i  = 8'd0;
      rst  = (rst_at != 0 && k == rst_at);
    end
    chk({nm, " pulses"}, pulses, exp_pulses);
    chk({nm, " pulses7"}, pulses7, exp_pulses);
    if (exp_pulses != 0) begin
      chk({nm, " latency"}, lat, 32);
      chk({nm, " busy_cycles"}, busy_n, 30);
    end
    chk({nm, " mean"}, mean_o, exp_mean);
    chk({nm, " mean7"}, mean7, exp_mean);
    chk({nm, " coe"}, coe_o, exp_coe);
    chk({nm, " coe7"}, coe7, exp_coe7);
    chk({nm, " busy_end"}, busy_o, 0);
    prev_mean = exp_mean; prev_coe = exp_coe; prev_coe7 = exp_coe7;
  endtask

  initial begin
    int sum, n, tgt, en, mean;

    tbl[0] = '{16, 100, 100, 128, 1, 100, 16'h001C, 16'h001C};
    tbl[1] = '{4,  10,  11,  0,   1, 10,  16'hFFF6, 16'hFFF6};
    tbl[2] = '{1,  250, 250, 0,   1, 250, 16'hFF06, 16'hFFC0};
    tbl[3] = '{8,  20,  20,  128, 1, 20,  16'h006C, 16'h003F};
    tbl[4] = '{8,  200, 200, 0,   1, 200, 16'hFF38, 16'hFFC0};
    tbl[5] = '{16, 100, 100, 128, 0, 100, 16'h0000, 16'h0000};
    tbl[6] = '{3,  255, 255, 0,   1, 255, 16'hFF01, 16'hFFC0};
    tbl[7] = '{2,  0,   255, 255, 1, 127, 16'h0080, 16'h003F};

    // Reset with random inputs, then one quiet cycle after release
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        rst = 1'b0; de_i = 1'b0; vs_i = 1'b0;
      end else begin
        de_i = 1'($urandom_range(0, 1)); vs_i = 1'($urandom_range(0, 1));
        y_i = 8'($urandom_range(0, 255)); target_i = 8'($urandom_range(0, 255));
      end
      @(posedge clk); #1;
      chk("reset coe", coe_o, 0);
      chk("reset mean", mean_o, 0);
      chk("reset vld", coe_vld_o, 0);
      chk("reset busy", busy_o, 0);
      chk("reset busy7", busy7, 0);
    end
    de_i = 1'b0; vs_i = 1'b0;
    @(posedge clk); #1;

    // Directed frames from the table
    for (int t = 0; t < 8; t++) begin
      q_pix.delete();
      for (int i = 0; i < tbl[t].n; i++) q_pix.push_back((i % 2 == 0) ? tbl[t].ya : tbl[t].yb);
      run_frame($sformatf("tbl%0d", t), tbl[t].tgt, tbl[t].en, 1,
                tbl[t].mean, tbl[t].coe, tbl[t].coe7, 0, 0);
    end

    // Empty frame: no pulse, outputs hold
    q_pix.delete();
    run_frame("empty", 7, 1, 0, prev_mean, prev_coe, prev_coe7, 0, 0);

    // en_i falling while idle zeroes the coefficient on the next clock without a pulse
    en_i = 1'b0;
    @(posedge clk); #1;
    chk("enfall coe", coe_o, 0);
    chk("enfall coe7", coe7, 0);
    chk("enfall vld", coe_vld_o, 0);
    chk("enfall mean", mean_o, prev_mean);
    en_i = 1'b1;

    // Second vs edge while dividing: dropped, its pixels discarded
    q_pix.delete();
    for (int i = 0; i < 16; i++) q_pix.push_back(100);
    run_frame("collide", 128, 1, 1, 100, 16'h001C, 16'h001C, 10, 0);
    q_pix.delete();
    q_pix.push_back(50); q_pix.push_back(51);
    run_frame("after_collide", 60, 1, 1, 50, 16'h000A, 16'h000A, 0, 0);

    // Reset during division cycle 15: aborted, everything back to zero
    q_pix.delete();
    for (int i = 0; i < 16; i++) q_pix.push_back(100);
    run_frame("midrst", 128, 1, 0, 0, 16'h0000, 16'h0000, 0, 15);

    // Random frames against the arithmetic model
    for (int r = 0; r < 10; r++) begin
      q_pix.delete();
      n = $urandom_range(1, 40);
      sum = 0;
      for (int i = 0; i < n; i++) begin
        q_pix.push_back($urandom_range(0, 255));
        sum += q_pix[i];
      end
      tgt  = $urandom_range(0, 255);
      en   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      mean = sum / n;
      run_frame($sformatf("rand%0d", r), tgt, en, 1, mean,
                model_coe(mean, tgt, en, 9), model_coe(mean, tgt, en, 7), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
